triangle_seq_checker: RTL and testbench
=======================================

Name: triangle_seq_checker

Overview:
- Receive-side monitor for the 4-bit up/down bouncing count sequence 0,1,…,14,15,14,…,1,0,1,… produced by the team's triangle counters.
- Samples the incoming count, acquires direction and locks onto the sequence.
- Once locked, flags any out-of-sequence value and reports peaks, valleys and completed periods.
- Sits at the consumer end of the counter bus, in self-test and link-check paths.

Parameters:
- WIDTH, 4, width of the sample bus.
- MAX, 15, turnaround value at the top of the sequence (2^WIDTH-1).
- LOCK_COUNT, 4, number of consecutive correct steps required to declare lock (1..15).
- PER_W, 8, width of the period counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  sample is present this cycle.
- sample  in  WIDTH  count value under check.
- clear_err  in  1  clears err_sticky.
- locked  out  1  checker locked to the sequence.
- dir_up  out  1  direction of the last accepted step (1 = up).
- peak  out  1  one-cycle pulse: MAX accepted while locked.
- valley  out  1  one-cycle pulse: 0 accepted while locked.
- seq_err  out  1  one-cycle pulse: mismatch while locked.
- err_sticky  out  1  latched error flag.
- period_count  out  PER_W  count of valleys accepted while locked; saturates at all-ones.

Behaviour:
- Reset: synchronous, active-high, evaluated on the rising clock edge. State := EMPTY. prev, match_cnt, dir_known := 0. All outputs := 0, including period_count.
- Only cycles with sample_valid=1 advance state. With sample_valid=0, all state holds and peak, valley and seq_err are 0. Gaps of any length are legal.
- All outputs are registered: effects of a sample accepted at edge N are visible after edge N (latency 1).
- Expected next value (exp), from prev and dir_up:
  - prev==MAX -> MAX-1.
  - prev==0 -> 1.
  - otherwise prev+1 if dir_up, else prev-1.
- States:
  - EMPTY: on a valid sample: prev := sample, dir_known := 0, match_cnt := 0, go ACQ.
  - ACQ, dir_known=0: on a valid sample s:
    - If s==prev+1 or s==prev-1 (no wrap; 0->MAX and MAX->0 are not steps): dir_up := (s>prev), dir_known := 1, match_cnt := 1.
    - Otherwise match_cnt := 0.
    - In both cases prev := s.
  - ACQ, dir_known=1: on a valid sample s:
    - If s==exp: match_cnt += 1, dir_up := (s>prev), prev := s.
    - Otherwise: prev := s, dir_known := 0, match_cnt := 0.
    - No seq_err is raised in ACQ.
  - Lock entry: when match_cnt reaches LOCK_COUNT, go LOCK and set locked := 1 on the same edge. With LOCK_COUNT=1, lock occurs on the first valid step.
  - LOCK: on a valid sample s:
    - If s==exp: prev := s, dir_up := (s>prev). Pulse peak if s==MAX. Pulse valley if s==0, and period_count += 1 (saturating).
    - Otherwise: pulse seq_err, err_sticky := 1, locked := 0, go ACQ with prev := s, dir_known := 0, match_cnt := 0.
- Turnaround direction: dir_up flips at the turnaround. After accepting MAX, dir_up=1; after the following MAX-1, dir_up=0.
- Arithmetic: all comparisons are unsigned WIDTH-bit. prev±1 is never taken across 0/MAX, because those cases are handled explicitly.
- err_sticky:
  - Set by any seq_err.
  - Cleared by clear_err.
  - If clear_err and a new seq_err occur in the same cycle, set wins.
  - Not cleared by re-lock.
- period_count: counts valleys only while locked. Holds at 2^PER_W-1 once saturated. Cleared only by reset.
- Reset mid-operation: overrides everything in the same cycle, including a simultaneous sample_valid. The next valid sample is treated as the EMPTY first sample.
- Sample value MAX held repeatedly while locked is a mismatch (exp=MAX-1).

Test Plan:
1. Lock-up: reset, then valid samples 0,1,2,3,4 on consecutive cycles (LOCK_COUNT=4) -> locked=0 through sample 3, locked=1 and dir_up=1 after sample 4. seq_err never asserts.
2. Full period: from case 1, feed 5..15, 14..0, 1 -> peak one cycle after 15, valley one cycle after 0, period_count=1, dir_up=0 after 14 and 1 after the final 1, no seq_err.
3. Error and relock: locked, ascending at 7, inject 9 -> seq_err one cycle, err_sticky=1, locked=0. Then 10,11,12,13 -> locked=1 after 13. err_sticky stays 1.
4. Valid gaps: locked, insert 3 idle cycles between samples 5 and 6 -> no outputs change during the gap, no pulses, lock held.
5. Error clear: clear_err in the same cycle as a new mismatch -> err_sticky=1. clear_err alone next cycle -> err_sticky=0.
6. Reset mid-lock plus saturation: PER_W=2, run 4 periods -> period_count holds at 3. Assert reset with sample_valid=1 -> next cycle all outputs 0. Then sample 8 followed by 6 -> stays ACQ, dir_known=0.

Source files
------------

// File: rtl/triangle_seq_checker.sv
// triangle_seq_checker: locks onto a bouncing up/down count and flags out-of-sequence samples.
module triangle_seq_checker #(
    parameter int WIDTH      = 4,
    parameter int MAX        = 15,
    parameter int LOCK_COUNT = 4,
    parameter int PER_W      = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    input  logic             clear_err,
    output logic             locked,
    output logic             dir_up,
    output logic             peak,
    output logic             valley,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [PER_W-1:0] period_count
);
    typedef enum logic [1:0] {EMPTY, ACQ, LOCK} state_t;
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [3:0]       LC  = 4'(LOCK_COUNT);
    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] exp_val;
    logic [3:0]       match_cnt;
    logic [3:0]       next_cnt;
    logic             dir_known;
    logic             is_step;
    logic             hit;
    // Turnaround values are handled explicitly so prev+/-1 never wraps.
    always_comb begin
        exp_val  = prev == TOP ? TOP - ONE : prev == '0 ? ONE : dir_up ? prev + ONE : prev - ONE;
        is_step  = (prev != TOP && sample == prev + ONE) || (prev != '0 && sample == prev - ONE);
        hit      = sample == exp_val;
        next_cnt = match_cnt + 4'd1;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= EMPTY;
            prev         <= '0;
            match_cnt    <= '0;
            dir_known    <= 1'b0;
            locked       <= 1'b0;
            dir_up       <= 1'b0;
            peak         <= 1'b0;
            valley       <= 1'b0;
            seq_err      <= 1'b0;
            err_sticky   <= 1'b0;
            period_count <= '0;
        end else begin
            peak    <= 1'b0;
            valley  <= 1'b0;
            seq_err <= 1'b0;
            if (clear_err) err_sticky <= 1'b0;
            if (sample_valid) begin
                prev <= sample;
                case (state)
                    EMPTY: begin
                        dir_known <= 1'b0;
                        match_cnt <= '0;
                        state     <= ACQ;
                    end
                    ACQ: begin
                        if (!dir_known) begin
                            if (is_step) begin
                                dir_up    <= sample > prev;
                                dir_known <= 1'b1;
                                match_cnt <= 4'd1;
                                if (LC == 4'd1) begin
                                    state  <= LOCK;
                                    locked <= 1'b1;
                                end
                            end else match_cnt <= '0;
                        end else if (hit) begin
                            match_cnt <= next_cnt;
                            dir_up    <= sample > prev;
                            if (next_cnt == LC) begin
                                state  <= LOCK;
                                locked <= 1'b1;
                            end
                        end else begin
                            dir_known <= 1'b0;
                            match_cnt <= '0;
                        end
                    end
                    LOCK: begin
                        if (hit) begin
                            dir_up <= sample > prev;
                            peak   <= sample == TOP;
                            valley <= sample == '0;
                            if (sample == '0 && !(&period_count)) period_count <= period_count + PER_W'(1);
                        end else begin
                            seq_err    <= 1'b1;
                            err_sticky <= 1'b1;
                            locked     <= 1'b0;
                            state      <= ACQ;
                            dir_known  <= 1'b0;
                            match_cnt  <= '0;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_triangle_seq_checker.sv
// tb_triangle_seq_checker: table-driven directed vectors for triangle_seq_checker (PER_W=2 to reach saturation).
module tb_triangle_seq_checker;
    logic       clock = 1'b0;
    logic       reset, sample_valid, clear_err;
    logic [3:0] sample;
    logic       locked, dir_up, peak, valley, seq_err, err_sticky;
    logic [1:0] period_count;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        logic       r, v, c;
        logic [3:0] s;
        logic [7:0] want;
    } vec_t;
    vec_t vecs[$];

    triangle_seq_checker #(.WIDTH(4), .MAX(15), .LOCK_COUNT(4), .PER_W(2)) dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .clear_err(clear_err), .locked(locked), .dir_up(dir_up), .peak(peak),
        .valley(valley), .seq_err(seq_err), .err_sticky(err_sticky), .period_count(period_count)
    );

    always #5 clock = ~clock;

    // Expected order: locked, dir_up, peak, valley, seq_err, err_sticky, period_count[1:0]
    function automatic void add(input logic r, v, input int s, input logic c,
                                input logic lk, du, pk, vl, se, es, input int pc);
        vec_t t;
        t.r = r; t.v = v; t.s = 4'(s); t.c = c;
        t.want = {lk, du, pk, vl, se, es, 2'(pc)};
        vecs.push_back(t);
    endfunction

    task automatic apply(input vec_t t, input string name);
        logic [7:0] got;
        reset = t.r; sample_valid = t.v; sample = t.s; clear_err = t.c;
        @(posedge clock);
        #1;
        got = {locked, dir_up, peak, valley, seq_err, err_sticky, period_count};
        n_cmp++;
        if (got !== t.want) begin
            n_bad++;
            $display("FAIL %s: got lk/du/pk/vl/se/es/pc=%b required %b", name, got, t.want);
        end
    endtask

    initial begin
        int pc;
        int lo;
        reset = 1'b1; sample_valid = 1'b0; sample = '0; clear_err = 1'b0;
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) add(0, 1, i, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 4, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 0, 9, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 6; i <= 14; i++) add(0, 1, i, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 15, 0, 1, 1, 1, 0, 0, 0, 0);
        for (int i = 14; i >= 1; i--) add(0, 1, i, 0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1);
        for (int i = 1; i <= 7; i++) add(0, 1, i, 0, 1, 1, 0, 0, 0, 0, 1);
        add(0, 1, 9, 0, 0, 1, 0, 0, 1, 1, 1);
        for (int i = 10; i <= 12; i++) add(0, 1, i, 0, 0, 1, 0, 0, 0, 1, 1);
        add(0, 1, 13, 0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 1, 5, 1, 0, 1, 0, 0, 1, 1, 1);
        add(0, 0, 5, 1, 0, 1, 0, 0, 0, 0, 1);
        for (int i = 6; i <= 8; i++) add(0, 1, i, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 1, 9, 0, 1, 1, 0, 0, 0, 0, 1);
        pc = 1; lo = 10;
        for (int p = 0; p < 3; p++) begin
            for (int i = lo; i <= 15; i++) add(0, 1, i, 0, 1, 1, i == 15, 0, 0, 0, pc);
            for (int i = 14; i >= 0; i--) begin
                if (i == 0) pc = pc == 3 ? 3 : pc + 1;
                add(0, 1, i, 0, 1, 0, 0, i == 0, 0, 0, pc);
            end
            lo = 1;
        end
        for (int i = 1; i <= 15; i++) add(0, 1, i, 0, 1, 1, i == 15, 0, 0, 0, 3);
        add(0, 1, 15, 0, 0, 1, 0, 0, 1, 1, 3);
        foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

        // Reset with a simultaneous valid sample, then a non-step pair and a fresh lock.
        begin
            vec_t t;
            t.r = 1; t.v = 1; t.s = 15; t.c = 0; t.want = 8'b0000_0000; apply(t, "reset_mid_lock");
            t.r = 0; t.s = 8;  apply(t, "first_after_reset");
            t.s = 6;           apply(t, "non_step_acq");
            t.s = 7; t.want = 8'b0100_0000; apply(t, "acq_dir_1");
            t.s = 8;           apply(t, "acq_dir_2");
            t.s = 9;           apply(t, "acq_dir_3");
            t.s = 10; t.want = 8'b1100_0000; apply(t, "relock_after_reset");
            t.v = 0; t.s = 0; apply(t, "idle_hold");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
